// File: rtl/fsm_seq_pkg.sv
// Shared state encoding and {a,b,c,d} drive patterns for the checkpoint-FSM sequencer.
// The drive patterns are Moore outputs, so they add no latency and apply no backpressure.
package fsm_seq_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLEAR  = 4'd1,
    STEP_C = 4'd2,
    STEP_A = 4'd3,
    DONE   = 4'd4,
    EXIT_A = 4'd5,
    EXIT_B = 4'd6,
    EXIT_D = 4'd7,
    ERR    = 4'd8
  } seq_state_t;

  // Bit order is {a,b,c,d}
  localparam logic [3:0] DRV_IDLE  = 4'b0001;
  localparam logic [3:0] DRV_CLEAR = 4'b0000;
  localparam logic [3:0] DRV_C     = 4'b0010;
  localparam logic [3:0] DRV_A     = 4'b1000;
  localparam logic [3:0] DRV_B     = 4'b0100;
  localparam logic [3:0] DRV_D     = 4'b0001;

  // Returns {checked, expected value} of fsm.finished for a sequencer state
  function automatic logic [1:0] fin_expect(seq_state_t s);
    logic [1:0] r;
    r = 2'b00;
    case (s)
      CLEAR, STEP_C, EXIT_B, EXIT_D, ERR: r = 2'b10;
      DONE:                               r = 2'b11;
      default:                            r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fsm_seq_watchdog.sv
// Cycle counter bounding the STEP_A wait; expired is high once TIMEOUT-1 counts accumulate.
// Combinational compare on the registered count; no backpressure.
module fsm_seq_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Walks the checkpoint FSM INIT->S0->S2->S3 and back to INIT; done 5 cycles after req, idle after 9.
// req ignored while busy; build with FSM_SEQ_INTEGRITY_EN to abort when finished disagrees with the state.
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic busy,
  output logic done,
  output logic err,
  input  logic finished,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic fsm_rst
);

  seq_state_t state;
  seq_state_t nxt;
  logic [3:0] drv;
  logic       expired;
  logic       wd_clr;
  logic       wd_en;
`ifdef FSM_SEQ_INTEGRITY_EN
  logic [1:0] fin_chk;
`endif

  // Counter is held at zero outside STEP_A, so it starts from zero on every entry
  assign wd_clr = (state != STEP_A);
  assign wd_en  = (state == STEP_A) && !finished;

  fsm_seq_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt     = IDLE;
    drv     = DRV_IDLE;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    fsm_rst = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        nxt  = req ? CLEAR : IDLE;
      end
      CLEAR: begin
        drv = DRV_CLEAR;
        nxt = STEP_C;
      end
      STEP_C: begin
        drv = DRV_C;
        nxt = STEP_A;
      end
      STEP_A: begin
        drv = DRV_A;
        // finished takes priority over a timeout in the same cycle
        if (finished)     nxt = DONE;
        else if (expired) nxt = ERR;
        else              nxt = STEP_A;
      end
      DONE: begin
        drv  = DRV_A;
        done = 1'b1;
        nxt  = EXIT_A;
      end
      EXIT_A: begin
        drv = DRV_CLEAR;
        nxt = EXIT_B;
      end
      EXIT_B: begin
        drv = DRV_B;
        nxt = EXIT_D;
      end
      EXIT_D: begin
        drv = DRV_D;
        nxt = IDLE;
      end
      ERR: begin
        fsm_rst = 1'b1;
        err     = 1'b1;
        nxt     = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
`ifdef FSM_SEQ_INTEGRITY_EN
    fin_chk = fin_expect(state);
    if (fin_chk[1] && (finished != fin_chk[0])) nxt = ERR;
`endif
  end

  assign {a, b, c, d} = drv;

endmodule
